// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory initiator: byte/half/word loads and stores onto a word-wide memory,
// with sub-word stores done as read-modify-write. Define DMEM_MISALIGN_TRAP_EN to trap misaligned requests.
module dmem_access_unit #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic {S_IDLE, S_RMW_WR} state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_e            state_q, state_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic [DATA_W-1:0] merge_q, merge_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [1:0]        eff_size;
    logic [ADDR_W-1:0] eff_addr;
    logic              req_err;
    logic              accept;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merge_data;

    // Request qualification: either trap bad alignment, or coerce it into an aligned access.
    always_comb begin
        eff_size = req_size;
        eff_addr = req_addr;
        req_err  = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        req_err = (req_size == 2'b11)
               || (req_size == SZ_HALF && req_addr[0])
               || (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
`else
        if (req_size == 2'b11) eff_size = SZ_WORD;
        if (eff_size == SZ_HALF)      eff_addr[0]   = 1'b0;
        else if (eff_size == SZ_WORD) eff_addr[1:0] = 2'b00;
`endif
    end

    always_comb begin
        ld_byte = mem_rdata[{eff_addr[1:0], 3'b000} +: 8];
        ld_half = mem_rdata[{eff_addr[1], 4'b0000} +: 16];
        case (eff_size)
            SZ_BYTE: load_data = {{24{!req_unsigned && ld_byte[7]}}, ld_byte};
            SZ_HALF: load_data = {{16{!req_unsigned && ld_half[15]}}, ld_half};
            default: load_data = mem_rdata;
        endcase
        merge_data = mem_rdata;
        if (eff_size == SZ_BYTE) merge_data[{eff_addr[1:0], 3'b000} +: 8] = req_wdata[7:0];
        else                     merge_data[{eff_addr[1], 4'b0000} +: 16] = req_wdata[15:0];
    end

    always_comb begin
        // NOTE: every output and next-state signal gets a default first, so no path leaves one unassigned and infers a latch.
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        merge_d      = merge_q;
        addr_d       = addr_q;
        req_ready    = (state_q == S_IDLE) && !rst;
        accept       = req_valid && req_ready;
        mem_addr     = eff_addr;
        mem_wdata    = req_wdata;
        mem_we       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    resp_valid_d = 1'b1;
                    if (req_err) begin
                        resp_err_d = 1'b1;
                    end else if (!req_we) begin
                        resp_rdata_d = load_data;
                    end else if (eff_size == SZ_WORD) begin
                        mem_we = 1'b1;
                    end else begin
                        resp_valid_d = 1'b0;
                        merge_d      = merge_data;
                        addr_d       = eff_addr;
                        state_d      = S_RMW_WR;
                    end
                end
            end
            S_RMW_WR: begin
                // Reset abandons the pending write immediately rather than at the next edge.
                mem_addr     = addr_q;
                mem_wdata    = merge_q;
                mem_we       = !rst;
                resp_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            merge_q      <= '0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            merge_q      <= merge_d;
            addr_q       <= addr_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Initiator side of the data-memory port, sitting in the MEM stage between the pipeline and the word-wide data memory.
- Translates byte, halfword and word loads/stores into word accesses on the memory's addr/we/wdata/rdata interface.
- Sub-word stores are done as a two-cycle read-modify-write.
- Produces sign- or zero-extended load data, flags misaligned accesses, and stalls the pipeline during RMW.

Parameters:
- ADDR_W, 6, byte-address width; the memory word index is addr[ADDR_W-1:2].
- DATA_W, 32, data width; fixed at 32, with 4 byte lanes.

Ports:
- clk  input  1  clock; all state updates on the posedge.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1  one-cycle pulse; request complete.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned or reserved-size request; qualified by resp_valid.
- mem_addr  output  ADDR_W  memory byte address.
- mem_we  output  1  memory write enable.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  memory read data; combinational from mem_addr.

Behaviour:
- States: IDLE and RMW_WR. req_ready = (state == IDLE) && !rst. Accept = req_valid && req_ready.
- Reset (async): state = IDLE; resp_valid, resp_err, resp_rdata, the merge buffer and the latched address all clear to 0. mem_we is forced to 0 while rst is high.
- Lanes are little-endian: byte n = bits [8n+7:8n], n = addr[1:0]; the halfword lane is selected by addr[1].
- Misaligned means: half with addr[0] = 1, word with addr[1:0] != 0, or size 11.
- IDLE combinational outputs: mem_addr = req_addr, mem_wdata = req_wdata. mem_we = 1 only for an accepted, aligned word store.
- Load (IDLE, accepted, aligned): extract the lane from mem_rdata and extend per req_unsigned. Register it into resp_rdata; resp_valid = 1 on the next cycle (latency 1). Stay in IDLE.
- Word store: written in the accept cycle. resp_valid = 1 on the next cycle with resp_rdata = 0.
- Sub-word store, accept cycle:
  - mem_we = 0.
  - Latch merge buffer = mem_rdata with the addressed lane replaced by req_wdata[7:0] or [15:0].
  - Latch the address; go to RMW_WR.
- Sub-word store, RMW_WR:
  - mem_addr = latched address, mem_wdata = merge buffer, mem_we = 1, req_ready = 0.
  - Next state is IDLE; resp_valid = 1 on the following cycle.
  - Total latency from accept to resp_valid is 2 cycles.
- Error request: no write (mem_we stays 0). resp_valid and resp_err = 1 on the next cycle, resp_rdata = 0. Stay in IDLE.
- resp_valid and resp_err are high for exactly one cycle per accepted request; they are 0 in every other cycle.
- Back-to-back: a request is accepted in the IDLE cycle immediately after RMW_WR, so it observes the merged word. Up to one request is accepted per cycle while in IDLE.
- Reset asserted in RMW_WR: the write is abandoned, mem_we drops immediately, and no response is issued.
- req_* inputs are ignored when no request is accepted.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined: behaviour exactly as above; misaligned and size-11 requests produce resp_err and never access memory.
- Undefined:
  - resp_err is tied to 0.
  - Misaligned half/word requests force their low address bits to 0 and proceed as aligned accesses.
  - Size 11 is treated as word.

Test Plan:
- SW 0xDEADBEEF @0x08, then LW @0x08 -> mem_we high only in the SW accept cycle; LW resp_rdata = 0xDEADBEEF one cycle after accept.
- SB 0x5A @0x09 after the above -> req_ready low for 1 cycle; mem_we high only in RMW_WR with mem_wdata = 0xDEAD5AEF; resp_valid 2 cycles after accept.
- Loads from word 0xDEAD5AEF:
  - LB @0x09 -> 0x0000005A.
  - LB @0x0B -> 0xFFFFFFDE.
  - LBU @0x0B -> 0x000000DE.
  - LH @0x0A -> 0xFFFFDEAD.
  - LHU @0x08 -> 0x00005AEF.
- SW 0x11111111 @0x0A:
  - With DMEM_MISALIGN_TRAP_EN: resp_err = 1, mem_we never high, LW @0x08 still returns 0xDEAD5AEF.
  - Without it: LW @0x08 returns 0x11111111.
- SH 0xBEEF @0x06 with req_valid held, followed directly by LW @0x04 -> LW accepted the cycle after RMW_WR and returns 0xBEEF0000 (word initially 0).
- rst pulsed during RMW_WR -> mem_we goes 0 asynchronously, the target word is unchanged, resp_valid stays 0, and req_ready is 1 after reset releases.
